serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: latches x/y/cin on start, adds one bit per clock LSB-first, pulses done.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub port selecting x + ~y + 1 (cout=1 means no borrow).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       fa_s;

    // Returns {carry, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fa_s    = full_add(a_q[0], b_q[0], c_q);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = x;
`ifdef SERIAL_ADDER_SUB_EN
                    b_d     = sub ? ~y : y;
                    c_d     = sub ? 1'b1 : cin;
`else
                    b_d     = y;
                    c_d     = cin;
`endif
                    s_d     = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                s_d   = {fa_s[0], s_q[WIDTH-1:1]};
                c_d   = fa_s[1];
                cnt_d = cnt_q + CNT_ONE;
                // The counter reaches WIDTH on the final edge, so it never wraps.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s[0], s_q[WIDTH-1:1]};
                    cout_d  = fa_s[1];
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed/random ops plus an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, sub8;
    logic [7:0] x8, y8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start2, cin2, sub2;
    logic [1:0] x2, y2;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    logic [8:0] q8[$];
    logic [2:0] q2[$];
    int checks = 0;
    int passes = 0;
    logic prev_d8 = 1'b0;
    logic prev_d2 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .x(x2), .y(y2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub2),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic, result as {cout, sum}.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
        int r;
        if (s) r = int'(a) + (256 - int'(b));
        else   r = int'(a) + int'(b) + int'(c);
        return r[8:0];
    endfunction

    function automatic logic [2:0] ref2(input logic [1:0] a, input logic [1:0] b, input logic c);
        int r;
        r = int'(a) + int'(b) + int'(c);
        return r[2:0];
    endfunction

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        logic [8:0] e;
        if (done8 === 1'b1) begin
            check("done8_one_cycle", {63'd0, prev_d8}, 64'd0);
            if (q8.size() == 0) begin
                checks++;
                $display("FAIL done8_unexpected: got done=1 required no pending result");
            end else begin
                e = q8.pop_front();
                check("sum8", {56'd0, sum8}, {56'd0, e[7:0]});
                check("cout8", {63'd0, cout8}, {63'd0, e[8]});
            end
        end
        prev_d8 = done8;
    end

    // Monitor for the WIDTH=2 instance.
    always @(negedge clk) begin
        logic [2:0] e;
        if (done2 === 1'b1) begin
            check("done2_one_cycle", {63'd0, prev_d2}, 64'd0);
            if (q2.size() == 0) begin
                checks++;
                $display("FAIL done2_unexpected: got done=1 required no pending result");
            end else begin
                e = q2.pop_front();
                check("sum2", {62'd0, sum2}, {62'd0, e[1:0]});
                check("cout2", {63'd0, cout2}, {63'd0, e[2]});
            end
        end
        prev_d2 = done2;
    end

    // Caller must be between edges with the DUT idle or in DONE.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, input bit push);
        x8 = a; y8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
        if (push) q8.push_back(ref8(a, b, c, s));
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic wait_done8(output int cyc, output int bcnt, output bit ok, output bit stable);
        logic [7:0] s0;
        logic       c0;
        cyc = 0; bcnt = 0; ok = 0; stable = 1;
        s0 = sum8; c0 = cout8;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin
                ok = 1;
                break;
            end
            if (busy8) bcnt++;
            if (sum8 !== s0 || cout8 !== c0) stable = 0;
            @(posedge clk);
            cyc++;
        end
        if (!ok) begin
            checks++;
            $display("FAIL timeout8: got no done after %0d cycles required done", cyc);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic s, input bit b2b);
        int cyc, bcnt;
        bit ok, stable;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        issue8(a, b, c, s, 1'b1);
        wait_done8(cyc, bcnt, ok, stable);
        if (ok) begin
            check("latency8", 64'(cyc), 64'd8);
            check("busy8_cycles", 64'(bcnt), 64'd8);
            check("hold_during_run8", {63'd0, stable}, 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bcnt, dp;
        bit ok, stable;
        rst = 1'b1;
        start8 = 1'b0; x8 = 8'd0; y8 = 8'd0; cin8 = 1'b0; sub8 = 1'b0;
        start2 = 1'b0; x2 = 2'd0; y2 = 2'd0; cin2 = 1'b0; sub2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy8}, 64'd0);
        check("rst_done", {63'd0, done8}, 64'd0);
        check("rst_sum", {56'd0, sum8}, 64'd0);
        check("rst_cout", {63'd0, cout8}, 64'd0);
        rst = 1'b0;

        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

        // Stray start 3 cycles into RUN must be ignored.
        @(posedge clk);
        #1;
        issue8(8'h3C, 8'h21, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        x8 = 8'hEE; y8 = 8'hDD; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8(cyc, bcnt, ok, stable);
        // Back-to-back: start held during DONE.
        op8(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);

        // Reset in RUN cycle 4 aborts with no done.
        @(posedge clk);
        #1;
        issue8(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy8}, 64'd0);
        check("abort_done", {63'd0, done8}, 64'd0);
        check("abort_sum", {56'd0, sum8}, 64'd0);
        check("abort_cout", {63'd0, cout8}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dp = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dp++;
        end
        check("abort_no_done", 64'(dp), 64'd0);
        op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
        op8(8'h07, 8'h05, 1'b0, 1'b1, 1'b1);
        op8(8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), s,
                ($urandom_range(0, 1) == 1));
        end

        // Exhaustive WIDTH=2 sweep, back-to-back.
        @(posedge clk);
        #1;
        for (int v = 0; v < 32; v++) begin
            bit got;
            logic [4:0] vv;
            vv = 5'(v);
            x2 = vv[4:3]; y2 = vv[2:1]; cin2 = vv[0]; start2 = 1'b1;
            q2.push_back(ref2(vv[4:3], vv[2:1], vv[0]));
            @(posedge clk);
            #1 start2 = 1'b0;
            got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done2) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                checks++;
                $display("FAIL timeout2: got no done for combo %0d required done", v);
            end
        end
        repeat (3) @(posedge clk);
        check("q8_drained", 64'(q8.size()), 64'd0);
        check("q2_drained", 64'(q2.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
